// File: rtl/rx_ipv4_if.sv
// Byte-stream bundle between the Ethernet receive stage, the IPv4 parser and the transport layer.
// master = upstream/byte source side, slave = parser side.
interface rx_ipv4_if #(
    parameter int OCT = 8
);
    logic           rx_ethernet_data_v;
    logic [OCT-1:0] rx_ethernet_data;
    logic           rx_ipv4_data_v;
    logic [OCT-1:0] rx_ipv4_data;
    logic           rx_ipv4_done;
    logic           rx_ipv4_err;

    modport master (
        output rx_ethernet_data_v, rx_ethernet_data,
        input  rx_ipv4_data_v, rx_ipv4_data, rx_ipv4_done, rx_ipv4_err
    );

    modport slave (
        input  rx_ethernet_data_v, rx_ethernet_data,
        output rx_ipv4_data_v, rx_ipv4_data, rx_ipv4_done, rx_ipv4_err
    );
endinterface

// File: rtl/rx_ipv4.sv
// IPv4 header parser: validates header, forwards IP payload only (padding/FCS trimmed), pulses done/err per frame.
// Payload out 1 cycle after input byte; no backpressure, upstream is a free-running valid stream.
module rx_ipv4 #(
    parameter int OCT = 8
) (
    input  logic           RX_CLK,
    input  logic           rst,
    input  logic [31:0]    ip_addr,
    rx_ipv4_if.slave       rx,
    output logic [31:0]    rx_src_ip,
    output logic [OCT-1:0] rx_protocol,
    output logic [15:0]    rx_total_len
);
    typedef enum logic [2:0] {
        IDLE, HEADER, PAYLOAD, DRAIN, DROP, DONE, ERR
    } state_t;

    state_t         r_state;
    logic           r_v_d;
    logic [15:0]    r_cnt;
    logic [3:0]     r_ihl;
    logic [15:0]    r_tlen;
    logic [OCT-1:0] r_proto;
    logic [31:0]    r_src;
    logic [31:0]    r_dst;
    logic [15:0]    r_sum;
    logic [OCT-1:0] r_hi;
    logic           r_bad;
    logic [31:0]    r_src_ip;
    logic [OCT-1:0] r_protocol;
    logic [15:0]    r_total_len;
    logic           r_data_v;
    logic [OCT-1:0] r_data;
    logic           r_done;
    logic           r_err;

    logic           w_v;
    logic [OCT-1:0] w_d;
    logic [15:0]    w_cnt_inc;
    logic [15:0]    w_hlen;
    logic [16:0]    w_s17;
    logic [15:0]    w_sum_fold;
    logic [31:0]    w_dst;

    assign w_v        = rx.rx_ethernet_data_v;
    assign w_d        = rx.rx_ethernet_data;
    assign w_cnt_inc  = (r_cnt == 16'hFFFF) ? r_cnt : r_cnt + 16'd1;
    assign w_hlen     = {10'd0, r_ihl, 2'b00};
    assign w_s17      = {1'b0, r_sum} + {1'b0, r_hi, w_d};
    assign w_sum_fold = w_s17[15:0] + {15'd0, w_s17[16]};
    // With IHL=5 the last destination byte is also the last header byte, so merge it in-flight.
    assign w_dst      = (r_cnt == 16'd19) ? {r_dst[23:0], w_d} : r_dst;

    always_ff @(posedge RX_CLK) begin
        if (rst) begin
            r_state     <= IDLE;
            // Held high so a frame already in flight at reset is not mistaken for a new start.
            r_v_d       <= 1'b1;
            r_cnt       <= 16'd0;
            r_ihl       <= 4'd0;
            r_tlen      <= 16'd0;
            r_proto     <= '0;
            r_src       <= 32'd0;
            r_dst       <= 32'd0;
            r_sum       <= 16'd0;
            r_hi        <= '0;
            r_bad       <= 1'b0;
            r_src_ip    <= 32'd0;
            r_protocol  <= '0;
            r_total_len <= 16'd0;
            r_data_v    <= 1'b0;
            r_data      <= '0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_v_d    <= w_v;
            r_data_v <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_v && !r_v_d) begin
                        r_cnt <= 16'd1;
                        r_sum <= 16'd0;
                        r_hi  <= w_d;
                        r_ihl <= w_d[3:0];
                        r_bad <= 1'b1;
                        if (w_d[7:4] != 4'd4 || w_d[3:0] < 4'd5)
                            r_state <= DROP;
                        else
                            r_state <= HEADER;
                    end
                end
                HEADER: begin
                    if (!w_v) begin
                        r_err   <= 1'b1;
                        r_state <= ERR;
                    end else begin
                        r_cnt <= w_cnt_inc;
                        if (!r_cnt[0]) r_hi  <= w_d;
                        else           r_sum <= w_sum_fold;
                        if (r_cnt == 16'd2) r_tlen[15:8] <= w_d;
                        if (r_cnt == 16'd3) r_tlen[7:0]  <= w_d;
                        if (r_cnt == 16'd9) r_proto      <= w_d;
                        if (r_cnt >= 16'd12 && r_cnt <= 16'd15) r_src <= {r_src[23:0], w_d};
                        if (r_cnt >= 16'd16 && r_cnt <= 16'd19) r_dst <= {r_dst[23:0], w_d};
                        if (r_cnt == w_hlen - 16'd1) begin
                            if (w_sum_fold != 16'hFFFF || r_tlen < w_hlen) begin
                                r_bad   <= 1'b1;
                                r_state <= DROP;
                            end else if (w_dst != ip_addr && w_dst != 32'hFFFF_FFFF) begin
                                r_bad   <= 1'b0;
                                r_state <= DROP;
                            end else begin
                                r_src_ip    <= r_src;
                                r_protocol  <= r_proto;
                                r_total_len <= r_tlen;
                                r_state     <= (r_tlen == w_hlen) ? DRAIN : PAYLOAD;
                            end
                        end
                    end
                end
                PAYLOAD: begin
                    if (!w_v) begin
                        r_err   <= 1'b1;
                        r_state <= ERR;
                    end else begin
                        r_data_v <= 1'b1;
                        r_data   <= w_d;
                        r_cnt    <= w_cnt_inc;
                        if (r_cnt == r_tlen - 16'd1) r_state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (!w_v) begin
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                DROP: begin
                    if (!w_v) begin
                        r_err   <= r_bad;
                        r_state <= r_bad ? ERR : IDLE;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                DONE:    r_state <= IDLE;
                ERR:     r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign rx.rx_ipv4_data_v = r_data_v;
    assign rx.rx_ipv4_data   = r_data;
    assign rx.rx_ipv4_done   = r_done;
    assign rx.rx_ipv4_err    = r_err;
    assign rx_src_ip         = r_src_ip;
    assign rx_protocol       = r_protocol;
    assign rx_total_len      = r_total_len;
endmodule
